tomasulo_timing_recorder: RTL
=============================

// Module: tomasulo_timing_recorder
// PURPOSE
//  Downstream consumer of the Tomasulo core's per-instruction status vectors (issue/ex_start/ex_comp/write/commit).
//  Stamps the cycle on which each instruction first reaches each stage, building the classic Tomasulo timing table.
//  Detects completion (all committed), runaway runs (timeout) and stage-order violations.
//  Exposes the table through a combinational read port for the testbench/scoreboard.
// PARAMETERS
//  NUM_INSTRUCTIONS  8   instructions tracked; width of every status vector (params_pkg value)
//  CYC_W             8   cycle-stamp / cycle-counter width; timeout at 2**CYC_W-1
// PORTS
//  clk          in   1                       system clock
//  reset        in   1                       asynchronous, active-low reset
//  start        in   1                       pulse; run begins (driven from loading_complete)
//  issue        in   NUM_INSTRUCTIONS        per-instr stage flags (level or pulse; first rise counts)
//  ex_start     in   NUM_INSTRUCTIONS        "
//  ex_comp      in   NUM_INSTRUCTIONS        "
//  write        in   NUM_INSTRUCTIONS        "
//  commit       in   NUM_INSTRUCTIONS        "
//  rd_idx       in   $clog2(NUM_INSTRUCTIONS) table read: instruction index
//  rd_stage     in   3                       table read: stage_e (0 issue..4 commit)
//  rd_stamp     out  CYC_W                   stamp at [rd_idx][rd_stage]; 0 if not captured
//  rd_valid     out  1                       stamp at [rd_idx][rd_stage] captured
//  cycle_count  out  CYC_W                   current run cycle
//  busy         out  1                       state == RUN
//  done         out  1                       all commits captured (sticky until next start)
//  timeout      out  1                       run aborted at counter max (sticky until next start)
//  order_err    out  1                       stage captured before predecessor (sticky until next start)
//  err_idx      out  $clog2(NUM_INSTRUCTIONS) index of first violating instruction
// BEHAVIOUR
//  Reset (async, reset==0): state IDLE; all stamps/valids, cycle_count, busy, done, timeout, order_err, err_idx = 0.
//  FSM IDLE -> RUN on start; RUN -> DONE when all commit valids set, or cycle_count == 2**CYC_W-1 (timeout=1);
//   DONE -> RUN on start. start ignored in RUN.
//  Entering RUN: table, flags, err_idx cleared; cycle_count = 1 on first RUN cycle; +1 each RUN cycle; frozen in DONE.
//  Capture (RUN only): for each instr i, stage s: if flag[s][i]==1 && !valid[i][s] -> stamp = cycle_count, valid = 1.
//   Later reassertions never overwrite. Flags in IDLE/DONE ignored.
//  Multiple stages/instructions may capture in the same cycle; all captured.
//  Order check: capturing stage s>0 while valid[i][s-1]==0 and flag[s-1][i]==0 in the same cycle -> order_err=1.
//   Simultaneous capture of s-1 and s is legal. err_idx latched only on the first error (lowest i if several).
//  done asserts the cycle after the last commit is captured (DONE entry); commit and timeout same cycle -> done=1, timeout=0.
//  Read port purely combinational; rd_idx >= NUM_INSTRUCTIONS or rd_stage > 4 -> rd_stamp=0, rd_valid=0.
// CONFIGURATION
//  TOMASULO_REC_INORDER_COMMIT_EN defined:
//   also flags order_err when commit[i] captured while commit of any j<i is not valid/concurrent (program-order commit).
//  Not defined: commit order unchecked; only the per-instruction stage order is checked.
// STRUCTURE
//  params_pkg: NUM_INSTRUCTIONS, CYC_W, NUM_STAGES=5, typedef enum logic[2:0] stage_e {ST_ISSUE,ST_EX_START,ST_EX_COMP,
//   ST_WRITE,ST_COMMIT}, typedef enum rec_state_e {REC_IDLE,REC_RUN,REC_DONE}.
//  Sub-module tomasulo_stamp_row (one per instruction, generate loop): 5 stamps + valids + per-row order check;
//   top holds the FSM, counter, done/timeout/err aggregation and the read mux.
// TESTING
//  1 Reset mid-RUN (cycle 5) -> all outputs 0, state IDLE, rd_valid=0 for every entry.
//  2 start; instr0 issue@1, ex_start@2, ex_comp@4, write@5, commit@6 (N=1 build or others pre-committed)
//    -> stamps 1,2,4,5,6; done=1 the cycle after commit; cycle_count frozen at 6.
//  3 issue[3] held high for 4 cycles from cycle 2 -> stamp stays 2; reasserting in DONE changes nothing.
//  4 write[2] at cycle 7 with ex_comp[2] never set -> order_err=1, err_idx=2; ex_comp+write same cycle -> no error.
//  5 No commits, CYC_W=4 -> at cycle_count 15 DONE, timeout=1, done=0; start -> flags clear, cycle_count=1.
//  6 _EN defined: commit[1]@9 before commit[0]@10 -> order_err=1, err_idx=1; undefined -> order_err=0.

Source files
------------

// File: rtl/params_pkg.sv
// Shared sizes, stage encoding and recorder FSM states for the Tomasulo timing recorder.
package params_pkg;

  localparam int NUM_INSTRUCTIONS = 8;
  localparam int CYC_W            = 8;
  localparam int NUM_STAGES       = 5;

  typedef enum logic [2:0] {
    ST_ISSUE    = 3'd0,
    ST_EX_START = 3'd1,
    ST_EX_COMP  = 3'd2,
    ST_WRITE    = 3'd3,
    ST_COMMIT   = 3'd4
  } stage_e;

  typedef enum logic [1:0] {
    REC_IDLE = 2'd0,
    REC_RUN  = 2'd1,
    REC_DONE = 2'd2
  } rec_state_e;

endpackage

// File: rtl/tomasulo_stamp_row.sv
// One row of the timing table: first-rise cycle stamps for the five stages of a single
// instruction, plus the check that no stage is captured ahead of its predecessor.
module tomasulo_stamp_row
  import params_pkg::*;
#(
  parameter int CYC_W = params_pkg::CYC_W
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      clear,
  input  logic                                      capture_en,
  input  logic [params_pkg::NUM_STAGES-1:0]         flags,
  input  logic [CYC_W-1:0]                          cycle_count,
  output logic [params_pkg::NUM_STAGES-1:0][CYC_W-1:0] stamps,
  output logic [params_pkg::NUM_STAGES-1:0]         valids,
  output logic                                      order_viol
);

  logic [NUM_STAGES-1:0] capture;

  always_comb begin
    capture = '0;
    for (int s = 0; s < NUM_STAGES; s++) begin
      capture[s] = capture_en & flags[s] & ~valids[s];
    end
  end

  // A predecessor raised in the same cycle counts as in order.
  always_comb begin
    order_viol = 1'b0;
    for (int s = 1; s < NUM_STAGES; s++) begin
      if (capture[s] && !valids[s-1] && !flags[s-1]) begin
        order_viol = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stamps <= '0;
      valids <= '0;
    end else if (clear) begin
      stamps <= '0;
      valids <= '0;
    end else begin
      for (int s = 0; s < NUM_STAGES; s++) begin
        if (capture[s]) begin
          stamps[s] <= cycle_count;
          valids[s] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tomasulo_timing_recorder.sv
// Records the cycle each instruction first reaches each Tomasulo stage and flags completion,
// timeout and stage-order errors. Define TOMASULO_REC_INORDER_COMMIT_EN to also check program-order commit.
module tomasulo_timing_recorder
  import params_pkg::*;
#(
  parameter int NUM_INSTRUCTIONS = params_pkg::NUM_INSTRUCTIONS,
  parameter int CYC_W            = params_pkg::CYC_W,
  localparam int IDX_W           = (NUM_INSTRUCTIONS > 1) ? $clog2(NUM_INSTRUCTIONS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [NUM_INSTRUCTIONS-1:0] issue,
  input  logic [NUM_INSTRUCTIONS-1:0] ex_start,
  input  logic [NUM_INSTRUCTIONS-1:0] ex_comp,
  input  logic [NUM_INSTRUCTIONS-1:0] write,
  input  logic [NUM_INSTRUCTIONS-1:0] commit,
  input  logic [IDX_W-1:0]            rd_idx,
  input  logic [2:0]                  rd_stage,
  output logic [CYC_W-1:0]            rd_stamp,
  output logic                        rd_valid,
  output logic [CYC_W-1:0]            cycle_count,
  output logic                        busy,
  output logic                        done,
  output logic                        timeout,
  output logic                        order_err,
  output logic [IDX_W-1:0]            err_idx
);

  rec_state_e state, state_next;
  logic       run, start_run, finish_commit, finish_timeout;
  logic       all_commit_next, at_max;

  logic [NUM_STAGES-1:0][CYC_W-1:0] stamp_tab [NUM_INSTRUCTIONS];
  logic [NUM_STAGES-1:0]            valid_tab [NUM_INSTRUCTIONS];
  logic [NUM_INSTRUCTIONS-1:0]      commit_valid, row_viol, viol;
  logic [IDX_W-1:0]                 first_viol;

  assign run  = (state == REC_RUN);
  assign busy = run;

  for (genvar i = 0; i < NUM_INSTRUCTIONS; i++) begin : g_row
    tomasulo_stamp_row #(.CYC_W(CYC_W)) u_row (
      .clk         (clk),
      .reset       (reset),
      .clear       (start_run),
      .capture_en  (run),
      .flags       ({commit[i], write[i], ex_comp[i], ex_start[i], issue[i]}),
      .cycle_count (cycle_count),
      .stamps      (stamp_tab[i]),
      .valids      (valid_tab[i]),
      .order_viol  (row_viol[i])
    );
    assign commit_valid[i] = valid_tab[i][ST_COMMIT];
  end

  assign all_commit_next = &(commit_valid | (commit & {NUM_INSTRUCTIONS{run}}));
  assign at_max          = (cycle_count == {CYC_W{1'b1}});

`ifdef TOMASULO_REC_INORDER_COMMIT_EN
  // A commit is in program order if every older instruction has committed or commits now.
  always_comb begin
    logic prefix_ok;
    prefix_ok = 1'b1;
    viol      = '0;
    for (int i = 0; i < NUM_INSTRUCTIONS; i++) begin
      viol[i]   = row_viol[i] | (run & commit[i] & ~commit_valid[i] & ~prefix_ok);
      prefix_ok = prefix_ok & (commit_valid[i] | commit[i]);
    end
  end
`else
  assign viol = row_viol;
`endif

  always_comb begin
    first_viol = '0;
    for (int i = NUM_INSTRUCTIONS - 1; i >= 0; i--) begin
      if (viol[i]) first_viol = IDX_W'(i);
    end
  end

  always_comb begin
    state_next     = state;
    start_run      = 1'b0;
    finish_commit  = 1'b0;
    finish_timeout = 1'b0;
    unique case (state)
      REC_IDLE, REC_DONE: begin
        if (start) begin
          state_next = REC_RUN;
          start_run  = 1'b1;
        end
      end
      REC_RUN: begin
        if (all_commit_next) begin
          state_next    = REC_DONE;
          finish_commit = 1'b1;
        end else if (at_max) begin
          state_next     = REC_DONE;
          finish_timeout = 1'b1;
        end
      end
      default: state_next = REC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= REC_IDLE;
    else        state <= state_next;
  end

  // Counter freezes on the edge that leaves RUN so it reports the final cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_count <= '0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      order_err   <= 1'b0;
      err_idx     <= '0;
    end else if (start_run) begin
      cycle_count <= CYC_W'(1);
      done        <= 1'b0;
      timeout     <= 1'b0;
      order_err   <= 1'b0;
      err_idx     <= '0;
    end else if (run) begin
      if (state_next == REC_RUN) cycle_count <= cycle_count + CYC_W'(1);
      if (finish_commit)         done        <= 1'b1;
      if (finish_timeout)        timeout     <= 1'b1;
      if ((|viol) && !order_err) begin
        order_err <= 1'b1;
        err_idx   <= first_viol;
      end
    end
  end

  always_comb begin
    rd_stamp = '0;
    rd_valid = 1'b0;
    if ((32'(rd_idx) < NUM_INSTRUCTIONS) && (rd_stage < 3'(NUM_STAGES))) begin
      rd_stamp = stamp_tab[rd_idx][rd_stage];
      rd_valid = valid_tab[rd_idx][rd_stage];
    end
  end

endmodule
